sdram_burst_reader: RTL
=======================

Name: sdram_burst_reader

Overview:
- Parametrised Avalon-MM bursting read master for the HPS f2h_sdram0 port; successor to the fixed 64-bit, single-port SDRAM hookup.
- Takes a (base, count) read command.
- Issues aligned bursts with multiple reads outstanding, credit-limited by its own FIFO.
- Delivers data as a valid/ready stream to the framebuffer/rasteriser fetch path.

Parameters:
- ADDR_W, 29, Avalon word-address width.
- DATA_W, 64, data width; byteenable width is DATA_W/8.
- BURST_W, 8, burstcount width.
- MAX_BURST, 16, largest burst in words; power of 2, ≤ 2^(BURST_W-1).
- FIFO_DEPTH, 256, read FIFO depth in words; power of 2, ≥ 2*MAX_BURST.
- CNT_W, 24, width of the word_count command field.

Ports:
- clk_clk  in  1  system clock; everything is synchronous to its rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle request; accepted only while busy=0.
- cmd_base  in  ADDR_W  first word address.
- cmd_count  in  CNT_W  number of words to read.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when the last word is popped by the stream.
- avm_address  out  ADDR_W  burst start word address.
- avm_burstcount  out  BURST_W  burst length.
- avm_read  out  1  read request.
- avm_byteenable  out  DATA_W/8  tied all-ones.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data valid.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream word available.
- st_ready  in  1  consumer accepts.

Behaviour:
- Reset values: busy=0, done=0, avm_read=0, avm_address=0, avm_burstcount=0, st_valid=0. FIFO empty, all counters 0.
- Reset asserted mid-operation aborts the command. Reads still in flight are not tracked after reset; system-level reset guarantees the SDRAM port is also reset.
- States:
  - IDLE: cmd_start with cmd_count≠0 latches base and count, goes to ISSUE, busy=1 next cycle. cmd_count=0 pulses done on the next cycle, stays IDLE, issues no reads. cmd_start while busy is ignored.
  - ISSUE: computes len = min(remaining_issue, MAX_BURST - (addr mod MAX_BURST)), so no burst crosses a MAX_BURST-aligned boundary. Asserts avm_read with address and len only when credit ≥ len. Credit = FIFO_DEPTH - fifo_used - outstanding_words.
  - ISSUE handshake: while avm_waitrequest=1, avm_read, avm_address and avm_burstcount stay stable. The request is accepted on the cycle avm_read=1 and waitrequest=0. On acceptance: addr += len, remaining_issue -= len, outstanding_words += len. After the final acceptance, go to DRAIN.
  - DRAIN: waits until outstanding_words=0 and the FIFO is empty and the last word has been popped. Then done=1 for one cycle, busy=0, back to IDLE.
- Every avm_readdatavalid cycle writes avm_readdata into the FIFO and decrements outstanding_words. Acceptance and readdatavalid in the same cycle update outstanding_words by len-1 net.
- The FIFO cannot overflow by construction. A write to a full FIFO is an assertion failure.
- Stream: st_valid = FIFO non-empty. A pop occurs when st_valid & st_ready. st_data is valid combinationally from FIFO head (registered-output FIFO, zero added latency after the write cycle).
- Latency: first st_valid no earlier than 1 cycle after the first readdatavalid. Minimum start→avm_read is 1 cycle.
- Address arithmetic wraps modulo 2^ADDR_W. Counters are CNT_W wide; no saturation is needed.
- Back-to-back bursts: a new burst may be presented the cycle after acceptance.

Decomposition:
- Package alice_avalon_pkg holds:
  - ADDR_W/DATA_W/BURST_W defaults;
  - state enum (IDLE, ISSUE, DRAIN);
  - the len-computation function.
- One sub-module, sdram_rd_fifo: synchronous FIFO, parametrised width and depth, with used-count output.

Test Plan:
- Base 0x100, count 40, MAX_BURST 16, always ready, no waitrequest → bursts (0x100,16), (0x110,16), (0x120,8). 40 words streamed in order. Exactly one done pulse; busy falls with done.
- Base 0x10A, count 20 → bursts (0x10A,6), (0x110,14). No burst crosses a 16-word boundary.
- FIFO_DEPTH 32, st_ready=0, count 64 → at most 32 words outstanding+buffered. avm_read stays low once credit < len. Raising st_ready resumes; all 64 words arrive with no overflow.
- waitrequest held 5 cycles on the second burst → address and burstcount stable throughout. Burst accepted once; no duplicate.
- cmd_count=0 → done pulses the next cycle, avm_read never asserted. cmd_start pulsed mid-command → ignored.
- reset_reset asserted during ISSUE with 3 bursts issued → all outputs return to reset values immediately. A new command after reset runs correctly.

Source files
------------

// File: rtl/alice_avalon_pkg.sv
// Shared definitions for the SDRAM bursting read master: default bus widths,
// controller states and the burst-length rule.
package alice_avalon_pkg;

  localparam int DEF_ADDR_W  = 29;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_t;

  // Longest burst that neither overshoots the remaining words nor crosses a
  // max_burst-aligned boundary (max_burst is a power of two).
  function automatic logic [31:0] burst_len(input logic [31:0] remaining,
                                            input logic [31:0] addr,
                                            input logic [31:0] max_burst);
    logic [31:0] room;
    room = max_burst - (addr & (max_burst - 32'd1));
    return (remaining < room) ? remaining : room;
  endfunction

endpackage

// File: rtl/sdram_burst_reader_if.sv
// Avalon-MM read bus plus the outgoing valid/ready stream of the burst reader.
interface sdram_burst_reader_if
  import alice_avalon_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W
) ();

  logic [ADDR_W-1:0]   avm_address;
  logic [BURST_W-1:0]  avm_burstcount;
  logic                avm_read;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;

  logic [DATA_W-1:0]   st_data;
  logic                st_valid;
  logic                st_ready;

  modport master (
    output avm_address, avm_burstcount, avm_read, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output st_data, st_valid,
    input  st_ready
  );

  modport slave (
    input  avm_address, avm_burstcount, avm_read, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  st_data, st_valid,
    output st_ready
  );

endinterface

// File: rtl/sdram_rd_fifo.sv
// Synchronous read-data FIFO; head word is presented combinationally from the
// storage array, so data is visible the cycle after it is written.
module sdram_rd_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      used
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;

  assign do_rd   = rd_en && !empty;
  assign empty   = (used == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, do_rd})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // The credit scheme upstream must make this impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                  !(wr_en && used == (AW+1)'(DEPTH)));

endmodule

// File: rtl/sdram_burst_reader.sv
// Avalon-MM bursting read master: splits a (base, count) command into aligned
// bursts, limited by FIFO credit, and streams the returned words out.
//
// state | meaning
// IDLE  | waiting for cmd_start; count 0 just pulses done
// ISSUE | presenting bursts while words remain to be requested
// DRAIN | all bursts accepted; waiting for data to return and be popped
module sdram_burst_reader
  import alice_avalon_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BURST_W    = DEF_BURST_W,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int CNT_W      = 24
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                cmd_start,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [CNT_W-1:0]    cmd_count,
  output logic                busy,
  output logic                done,
  sdram_burst_reader_if.master bus
);

  localparam int UW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t         state;
  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]  remaining;
  logic [UW-1:0]     outstanding;
  logic [UW-1:0]     fifo_used;
  logic              fifo_empty;
  logic              accept;
  logic              rdv;
  logic              pop;
  logic [31:0]       first_len;
  logic [31:0]       next_len;
  logic [31:0]       committed;
  logic              can_issue;

  assign accept = bus.avm_read && !bus.avm_waitrequest;
  assign rdv    = bus.avm_readdatavalid;
  assign pop    = bus.st_valid && bus.st_ready;

  assign bus.avm_byteenable = '1;
  assign bus.st_valid       = !fifo_empty;

  assign first_len = burst_len(32'(cmd_count), 32'(cmd_base), MAX_BURST);
  assign next_len  = burst_len(32'(remaining), 32'(next_addr), MAX_BURST);

  // next_addr/remaining already exclude the burst on the bus, so a burst being
  // accepted this cycle is counted here before it reaches outstanding.
  assign committed = 32'(fifo_used) + 32'(outstanding)
                   + (bus.avm_read ? 32'(bus.avm_burstcount) : 32'd0);
  assign can_issue = (remaining != '0) && (committed + next_len <= 32'(FIFO_DEPTH));

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      bus.avm_read       <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_burstcount <= '0;
      next_addr          <= '0;
      remaining          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            if (cmd_count == '0) begin
              done <= 1'b1;
            end else begin
              busy               <= 1'b1;
              bus.avm_read       <= 1'b1;
              bus.avm_address    <= cmd_base;
              bus.avm_burstcount <= BURST_W'(first_len);
              next_addr          <= cmd_base + ADDR_W'(first_len);
              remaining          <= cmd_count - CNT_W'(first_len);
              state              <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!bus.avm_read || accept) begin
            if (can_issue) begin
              bus.avm_read       <= 1'b1;
              bus.avm_address    <= next_addr;
              bus.avm_burstcount <= BURST_W'(next_len);
              next_addr          <= next_addr + ADDR_W'(next_len);
              remaining          <= remaining - CNT_W'(next_len);
            end else begin
              bus.avm_read <= 1'b0;
              if (remaining == '0) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (outstanding == '0 &&
              (fifo_used == '0 || (fifo_used == UW'(1) && pop))) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      outstanding <= '0;
    end else if (accept && rdv) begin
      outstanding <= outstanding + UW'(bus.avm_burstcount) - 1'b1;
    end else if (accept) begin
      outstanding <= outstanding + UW'(bus.avm_burstcount);
    end else if (rdv) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  sdram_rd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .wr_en   (rdv),
    .wr_data (bus.avm_readdata),
    .rd_en   (pop),
    .rd_data (bus.st_data),
    .empty   (fifo_empty),
    .used    (fifo_used)
  );

endmodule
